fifo_1c_status: RTL

Single-clock synchronous FIFO, the parametrised successor of the basic single-clock FIFO. Adds synchronous active-low reset, a fill-level count, programmable almost-full and almost-empty thresholds, and a first-word-fall-through (FWFT) mode. Adds sticky overflow and underflow error flags, and guards the pointers so illegal operations are dropped. Used inside client datapaths wherever a shallow rate-matching buffer with level reporting is needed.

---
 rtl/fifo_1c_status.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fifo_1c_status.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_1c_status
// Purpose  : Single-clock synchronous FIFO with fill-level count, programmable
//            almost-full / almost-empty thresholds, sticky overflow/underflow
//            flags and an optional first-word-fall-through (FWFT) read port.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      sole clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   din          in   DW     write data
//   we           in   1      write request
//   re           in   1      read request (pop)
//   clr_err      in   1      clears overflow / underflow
//   dout         out  DW     read data (registered)
//   full         out  1      no free word
//   empty        out  1      no readable word
//   count        out  AW+1   words held, 0..2^AW
//   almost_full  out  1      count >= AF_LEVEL
//   almost_empty out  1      count <= AE_LEVEL
//   overflow     out  1      sticky: write attempted while full
//   underflow    out  1      sticky: read attempted while empty
// ============================================================================
module fifo_1c_status #(
  parameter int DW       = 16,
  parameter int AW       = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = (1 << AW) - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  input  logic          clr_err,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int          C_W     = AW + 1;
  localparam int          C_DEPTH = 1 << AW;
  localparam logic [AW:0] C_FULL  = C_W'(C_DEPTH);
  localparam logic [AW:0] C_AF    = C_W'(AF_LEVEL);
  localparam logic [AW:0] C_AE    = C_W'(AE_LEVEL);

  logic [DW-1:0] r_mem [C_DEPTH];

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_dout;
  logic          r_full;
  logic          r_empty;
  logic          r_af;
  logic          r_ae;
  logic          r_ovf;
  logic          r_udf;

  logic          w_wr;
  logic          w_rd;
  logic [AW:0]   w_count_nxt;

  // Acceptance uses only the registered flags, so an illegal request can
  // never move a pointer.
  assign w_wr = we & ~r_full;
  assign w_rd = re & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Storage array: no reset, contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

  // Write side, level, threshold and error bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_FULL);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
      // A new error wins over a coincident clear.
      if (we && r_full) begin
        r_ovf <= 1'b1;
      end else if (clr_err) begin
        r_ovf <= 1'b0;
      end
      if (re && r_empty) begin
        r_udf <= 1'b1;
      end else if (clr_err) begin
        r_udf <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // dout doubles as the prefetch register; empty=0 marks it valid.
      // It is refilled from RAM whenever it is invalid or being popped, so a
      // continuous pop stream sees one word per cycle.
      logic w_ram_has;
      logic w_load;

      assign w_ram_has = (r_wptr != r_rptr);
      assign w_load    = w_ram_has & (r_empty | w_rd);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rptr  <= '0;
          r_dout  <= '0;
          r_empty <= 1'b1;
        end else if (w_load) begin
          r_dout  <= r_mem[r_rptr[AW-1:0]];
          r_rptr  <= r_rptr + 1'b1;
          r_empty <= 1'b0;
        end else if (w_rd) begin
          r_empty <= 1'b1;
        end
      end
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rptr  <= '0;
          r_dout  <= '0;
          r_empty <= 1'b1;
        end else begin
          if (w_rd) begin
            r_dout <= r_mem[r_rptr[AW-1:0]];
            r_rptr <= r_rptr + 1'b1;
          end
          r_empty <= (w_count_nxt == '0);
        end
      end
    end
  endgenerate

  assign dout         = r_dout;
  assign full         = r_full;
  assign empty        = r_empty;
  assign count        = r_count;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
`default_nettype wire
